// File: rtl/debug_dump_serializer_pkg.sv
// Shared types and constants for the debug dump serializer: FSM states,
// frame header magic and the layout of the four pipeline latch snapshots.
package debug_dump_serializer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_LATCH,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_PUSH,
        ST_TRAILER,
        ST_DONE
    } dump_state_t;

    localparam logic [7:0] HEADER_MAGIC = 8'hD5;
    localparam int         WORD_W       = 32;

    localparam int IF_ID_W  = 64;
    localparam int ID_EX_W  = 139;
    localparam int EX_MEM_W = 76;
    localparam int MEM_WB_W = 71;

    localparam int IF_ID_WORDS  = 2;
    localparam int ID_EX_WORDS  = 5;
    localparam int EX_MEM_WORDS = 3;
    localparam int MEM_WB_WORDS = 3;
    localparam int LATCH_WORDS  = IF_ID_WORDS + ID_EX_WORDS + EX_MEM_WORDS + MEM_WB_WORDS;

    // Total words in one frame, header and trailer included
    function automatic logic [23:0] frame_word_count(input int num_regs, input int mem_words,
                                                     input logic inc_mem);
        int n;
        n = 1 + LATCH_WORDS + num_regs + (inc_mem ? mem_words : 0) + 1;
        return 24'(n);
    endfunction

    function automatic logic [31:0] header_word(input int num_regs, input int mem_words,
                                                input logic inc_mem);
        return {HEADER_MAGIC, frame_word_count(num_regs, mem_words, inc_mem)};
    endfunction

endpackage

// File: rtl/debug_dump_serializer_word_mux.sv
// Combinational selector of one 32-bit word out of the latch snapshot.
// Words run IF_ID, ID_EX, EX_MEM, MEM_WB, each least significant word first,
// with the top word of each latch zero-padded.
module dump_word_mux
    import debug_dump_serializer_pkg::*;
(
    input  logic [IF_ID_W-1:0]  if_id,
    input  logic [ID_EX_W-1:0]  id_ex,
    input  logic [EX_MEM_W-1:0] ex_mem,
    input  logic [MEM_WB_W-1:0] mem_wb,
    input  logic [3:0]          word_idx,
    output logic [WORD_W-1:0]   word
);

    localparam int PAD_W = LATCH_WORDS * WORD_W;

    logic [PAD_W-1:0] padded;

    // Lay the latches out back-to-back, each starting on a word boundary
    always_comb begin
        padded = '0;
        padded[0 +: IF_ID_W] = if_id;
        padded[IF_ID_WORDS*WORD_W +: ID_EX_W] = id_ex;
        padded[(IF_ID_WORDS+ID_EX_WORDS)*WORD_W +: EX_MEM_W] = ex_mem;
        padded[(IF_ID_WORDS+ID_EX_WORDS+EX_MEM_WORDS)*WORD_W +: MEM_WB_W] = mem_wb;
    end

    // An index past the last latch word reads as zero
    always_comb begin
        word = '0;
        if (int'(word_idx) < LATCH_WORDS) begin
            word = padded[int'(word_idx)*WORD_W +: WORD_W];
        end
    end

endmodule

// File: rtl/debug_dump_serializer.sv
// Writer side of the debug transmit FIFO. On a dump request it snapshots the
// pipeline latches and streams header, latch words, register file, optional
// data memory and an XOR trailer into the FIFO, honouring back-pressure.
module debug_dump_serializer
    import debug_dump_serializer_pkg::*;
#(
    parameter int DATA_MEM_ADDR_WIDTH = 8,
    parameter int MEM_WORDS           = 64,
    parameter int NUM_REGS            = 32,
    parameter int READ_LATENCY        = 1
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_start,
    input  logic                           i_include_mem,
    input  logic [IF_ID_W-1:0]             i_IF_ID_latch,
    input  logic [ID_EX_W-1:0]             i_ID_EX_latch,
    input  logic [EX_MEM_W-1:0]            i_EX_MEM_latch,
    input  logic [MEM_WB_W-1:0]            i_MEM_WB_latch,
    output logic [4:0]                     o_reg_addr_to_read,
    input  logic [31:0]                    i_register_content,
    output logic [DATA_MEM_ADDR_WIDTH-1:0] o_addr_to_read_mem_data,
    input  logic [31:0]                    i_mem_data_content,
    input  logic                           i_fifo_full,
    output logic [31:0]                    o_data_to_fifo,
    output logic                           o_write_en_fifo,
    output logic                           o_busy,
    output logic                           o_done
);

    localparam int MAX_ITEMS = (NUM_REGS > MEM_WORDS) ? NUM_REGS : MEM_WORDS;
    localparam int IDX_W     = $clog2(MAX_ITEMS + 1);

    localparam logic [IDX_W-1:0] LAST_REG   = IDX_W'(NUM_REGS - 1);
    localparam logic [IDX_W-1:0] LAST_MEM   = IDX_W'(MEM_WORDS - 1);
    localparam logic [3:0]       LAST_LATCH = 4'(LATCH_WORDS - 1);
    localparam logic [1:0]       WAIT_LAST  = (READ_LATENCY == 0) ? 2'd0 : 2'(READ_LATENCY - 1);

    dump_state_t state, next_state;

    logic [IF_ID_W-1:0]             snap_if_id;
    logic [ID_EX_W-1:0]             snap_id_ex;
    logic [EX_MEM_W-1:0]            snap_ex_mem;
    logic [MEM_WB_W-1:0]            snap_mem_wb;
    logic                           inc_mem_q;
    logic [31:0]                    checksum;
    logic [3:0]                     latch_idx;
    logic [IDX_W-1:0]               rd_idx;
    logic                           sec_mem;
    logic [1:0]                     wait_cnt;
    logic [31:0]                    hold;
    logic [4:0]                     reg_addr_q;
    logic [DATA_MEM_ADDR_WIDTH-1:0] mem_addr_q;

    logic [31:0]                    latch_word;
    logic [31:0]                    word_out;
    logic                           wr_fire;
    logic                           rd_active;
    logic                           last_item;
    logic                           go_trailer;
    logic [31:0]                    rd_data;
    logic [4:0]                     reg_addr_calc;
    logic [DATA_MEM_ADDR_WIDTH-1:0] mem_addr_calc;

    dump_word_mux u_word_mux (
        .if_id    (snap_if_id),
        .id_ex    (snap_id_ex),
        .ex_mem   (snap_ex_mem),
        .mem_wb   (snap_mem_wb),
        .word_idx (latch_idx),
        .word     (latch_word)
    );

    assign rd_active     = (state == ST_RD_ADDR) || (state == ST_RD_WAIT);
    assign last_item     = sec_mem ? (rd_idx == LAST_MEM) : (rd_idx == LAST_REG);
    assign go_trailer    = last_item && (sec_mem || !inc_mem_q);
    assign rd_data       = sec_mem ? i_mem_data_content : i_register_content;
    assign reg_addr_calc = 5'(rd_idx);
    assign mem_addr_calc = DATA_MEM_ADDR_WIDTH'({rd_idx, 2'b00});

    // Addresses follow the index only while a read is in flight, otherwise hold
    assign o_reg_addr_to_read      = (rd_active && !sec_mem) ? reg_addr_calc : reg_addr_q;
    assign o_addr_to_read_mem_data = (rd_active && sec_mem)  ? mem_addr_calc : mem_addr_q;

    assign o_data_to_fifo  = word_out;
    assign o_write_en_fifo = wr_fire;
    assign o_busy          = (state != ST_IDLE);
    assign o_done          = (state == ST_DONE);

    // State register; reset abandons any partial frame
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, pending word and write strobe; a write only fires when the FIFO has room
    always_comb begin
        next_state = state;
        word_out   = '0;
        wr_fire    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start) next_state = ST_HEADER;
            end
            ST_HEADER: begin
                word_out = header_word(NUM_REGS, MEM_WORDS, inc_mem_q);
                if (!i_fifo_full) begin
                    wr_fire    = 1'b1;
                    next_state = ST_LATCH;
                end
            end
            ST_LATCH: begin
                word_out = latch_word;
                if (!i_fifo_full) begin
                    wr_fire = 1'b1;
                    if (latch_idx == LAST_LATCH) next_state = ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: begin
                next_state = (READ_LATENCY == 0) ? ST_PUSH : ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (wait_cnt == WAIT_LAST) next_state = ST_PUSH;
            end
            ST_PUSH: begin
                word_out = hold;
                if (!i_fifo_full) begin
                    wr_fire    = 1'b1;
                    next_state = go_trailer ? ST_TRAILER : ST_RD_ADDR;
                end
            end
            ST_TRAILER: begin
                word_out = checksum;
                if (!i_fifo_full) begin
                    wr_fire    = 1'b1;
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Snapshot, counters, read hold register, checksum and held addresses
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            snap_if_id  <= '0;
            snap_id_ex  <= '0;
            snap_ex_mem <= '0;
            snap_mem_wb <= '0;
            inc_mem_q   <= 1'b0;
            checksum    <= '0;
            latch_idx   <= '0;
            rd_idx      <= '0;
            sec_mem     <= 1'b0;
            wait_cnt    <= '0;
            hold        <= '0;
            reg_addr_q  <= '0;
            mem_addr_q  <= '0;
        end else begin
            if (wr_fire) checksum <= checksum ^ word_out;
            case (state)
                ST_IDLE: begin
                    reg_addr_q <= '0;
                    mem_addr_q <= '0;
                    if (i_start) begin
                        snap_if_id  <= i_IF_ID_latch;
                        snap_id_ex  <= i_ID_EX_latch;
                        snap_ex_mem <= i_EX_MEM_latch;
                        snap_mem_wb <= i_MEM_WB_latch;
                        inc_mem_q   <= i_include_mem;
                        checksum    <= '0;
                        latch_idx   <= '0;
                        rd_idx      <= '0;
                        sec_mem     <= 1'b0;
                    end
                end
                ST_LATCH: begin
                    if (wr_fire) latch_idx <= latch_idx + 4'd1;
                end
                ST_RD_ADDR: begin
                    if (sec_mem) mem_addr_q <= mem_addr_calc;
                    else         reg_addr_q <= reg_addr_calc;
                    wait_cnt <= '0;
                    if (READ_LATENCY == 0) hold <= rd_data;
                end
                ST_RD_WAIT: begin
                    if (sec_mem) mem_addr_q <= mem_addr_calc;
                    else         reg_addr_q <= reg_addr_calc;
                    if (wait_cnt == WAIT_LAST) hold <= rd_data;
                    else                       wait_cnt <= wait_cnt + 2'd1;
                end
                ST_PUSH: begin
                    if (wr_fire) begin
                        if (last_item && !sec_mem) begin
                            sec_mem <= 1'b1;
                            rd_idx  <= '0;
                        end else begin
                            rd_idx <= rd_idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_dump_serializer.sv
// Self-checking bench: three serializers (read latency 1, 0 and 3) share the
// stimulus; each frame is compared word by word against a frame built from
// the frame-format rules, plus hand-computed literal words.
module tb_debug_dump_serializer;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_include_mem;
    logic        i_fifo_full;
    logic [63:0] if_id;
    logic [138:0] id_ex;
    logic [75:0] ex_mem;
    logic [70:0] mem_wb;
    logic [NI-1:0] start_v;

    logic [31:0] data_o     [NI];
    logic        wen_o      [NI];
    logic        busy_o     [NI];
    logic        done_o     [NI];
    logic [4:0]  reg_addr_o [NI];
    logic [7:0]  mem_addr_o [NI];
    logic [31:0] reg_data   [NI];
    logic [31:0] mem_data   [NI];

    int          n_pass = 0;
    int          n_total = 0;
    int          ptr      [NI];
    int          done_cnt [NI];
    logic [31:0] exp_q [$];
    logic [31:0] cap [256];
    logic        cur_inc = 1'b0;
    logic        bp_on = 1'b0;
    logic [31:0] first_trailer;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        logic [4:0] ra1, ra2, ra3, ra_sel;
        logic [7:0] ma1, ma2, ma3, ma_sel;

        // Read ports modelled as address delay lines of the instance's latency
        always @(posedge clk) begin
            ra1 <= reg_addr_o[g]; ra2 <= ra1; ra3 <= ra2;
            ma1 <= mem_addr_o[g]; ma2 <= ma1; ma3 <= ma2;
        end
        assign ra_sel = (LAT == 0) ? reg_addr_o[g] : ((LAT == 1) ? ra1 : ra3);
        assign ma_sel = (LAT == 0) ? mem_addr_o[g] : ((LAT == 1) ? ma1 : ma3);
        assign reg_data[g] = 32'(ra_sel) * 32'h0101_0101;
        assign mem_data[g] = 32'hA000_0000 + 32'(ma_sel >> 2);

        debug_dump_serializer #(.READ_LATENCY(LAT)) u_dut (
            .i_clk                   (clk),
            .i_reset                 (i_reset),
            .i_start                 (start_v[g]),
            .i_include_mem           (i_include_mem),
            .i_IF_ID_latch           (if_id),
            .i_ID_EX_latch           (id_ex),
            .i_EX_MEM_latch          (ex_mem),
            .i_MEM_WB_latch          (mem_wb),
            .o_reg_addr_to_read      (reg_addr_o[g]),
            .i_register_content      (reg_data[g]),
            .o_addr_to_read_mem_data (mem_addr_o[g]),
            .i_mem_data_content      (mem_data[g]),
            .i_fifo_full             (i_fifo_full),
            .o_data_to_fifo          (data_o[g]),
            .o_write_en_fifo         (wen_o[g]),
            .o_busy                  (busy_o[g]),
            .o_done                  (done_o[g])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_total++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp_v);
    endtask

    // Reference frame from the format rules and the current latch values
    task automatic build_frame(input logic inc);
        logic [31:0] x;
        int n;
        exp_q.delete();
        n = 1 + 13 + 32 + (inc ? 64 : 0) + 1;
        exp_q.push_back(32'hD500_0000 | 32'(n));
        for (int k = 0; k < 2; k++) exp_q.push_back(32'(if_id  >> (32*k)));
        for (int k = 0; k < 5; k++) exp_q.push_back(32'(id_ex  >> (32*k)));
        for (int k = 0; k < 3; k++) exp_q.push_back(32'(ex_mem >> (32*k)));
        for (int k = 0; k < 3; k++) exp_q.push_back(32'(mem_wb >> (32*k)));
        for (int r = 0; r < 32; r++) exp_q.push_back(32'(r) * 32'h0101_0101);
        if (inc) for (int k = 0; k < 64; k++) exp_q.push_back(32'hA000_0000 + 32'(k));
        x = '0;
        foreach (exp_q[i]) x ^= exp_q[i];
        exp_q.push_back(x);
        cur_inc = inc;
    endtask

    task automatic check_cycle();
        for (int i = 0; i < NI; i++) begin
            if (wen_o[i]) begin
                chk($sformatf("wen_while_full_i%0d", i), 32'(i_fifo_full), 32'd0);
                if (ptr[i] < exp_q.size()) begin
                    chk($sformatf("word%0d_i%0d", ptr[i], i), data_o[i], exp_q[ptr[i]]);
                end else begin
                    n_total++;
                    $display("FAIL extra_write_i%0d: got write %0d required at most %0d", i, ptr[i] + 1, exp_q.size());
                end
                if (i == 0 && ptr[0] < 256) cap[ptr[0]] = data_o[0];
                ptr[i]++;
            end
            if (busy_o[i] && !cur_inc) chk($sformatf("mem_addr_zero_i%0d", i), 32'(mem_addr_o[i]), 32'd0);
            if (done_o[i]) begin
                done_cnt[i]++;
                chk($sformatf("frame_len_i%0d", i), 32'(ptr[i]), 32'(exp_q.size()));
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        if (bp_on) i_fifo_full = 1'($urandom_range(0, 1));
    endtask

    task automatic set_pattern(input int p);
        if (p == 0) begin
            if_id  = 64'h1111_2222_3333_4444;
            id_ex  = '1;
            ex_mem = '1;
            mem_wb = '1;
        end else begin
            if_id  = 64'hDEAD_BEEF_0BAD_F00D;
            id_ex  = {11'h2A5, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210};
            ex_mem = {12'hC3C, 64'h5555_AAAA_0F0F_F0F0};
            mem_wb = {7'h5B, 64'h8000_0000_0000_0001};
        end
    endtask

    task automatic do_start(input logic inc, input logic [NI-1:0] mask);
        build_frame(inc);
        for (int i = 0; i < NI; i++) begin
            if (mask[i]) begin
                ptr[i] = 0;
                done_cnt[i] = 0;
            end
        end
        i_include_mem = inc;
        start_v = mask;
        tick();
        start_v = '0;
        i_include_mem = 1'b0;
        for (int i = 0; i < NI; i++) if (mask[i]) chk($sformatf("busy_after_start_i%0d", i), 32'(busy_o[i]), 32'd1);
    endtask

    task automatic wait_frames();
        int c;
        c = 0;
        while (c < 4000 && !(done_cnt[0] > 0 && done_cnt[1] > 0 && done_cnt[2] > 0)) begin
            tick();
            c++;
        end
        repeat (3) tick();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("done_pulses_i%0d", i), 32'(done_cnt[i]), 32'd1);
            chk($sformatf("writes_i%0d", i), 32'(ptr[i]), 32'(exp_q.size()));
            chk($sformatf("idle_i%0d", i), 32'(busy_o[i]), 32'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("%s_data_i%0d", tag, i), data_o[i], 32'd0);
            chk($sformatf("%s_wen_i%0d", tag, i), 32'(wen_o[i]), 32'd0);
            chk($sformatf("%s_busy_i%0d", tag, i), 32'(busy_o[i]), 32'd0);
            chk($sformatf("%s_done_i%0d", tag, i), 32'(done_o[i]), 32'd0);
            chk($sformatf("%s_raddr_i%0d", tag, i), 32'(reg_addr_o[i]), 32'd0);
            chk($sformatf("%s_maddr_i%0d", tag, i), 32'(mem_addr_o[i]), 32'd0);
        end
    endtask

    initial begin
        int c;
        i_reset = 1'b0;
        i_include_mem = 1'b0;
        i_fifo_full = 1'b0;
        start_v = '0;
        set_pattern(0);
        for (int i = 0; i < NI; i++) begin
            ptr[i] = 0;
            done_cnt[i] = 0;
        end
        repeat (3) tick();
        check_all_zero("reset");
        i_reset = 1'b1;
        tick();

        // Full frame with memory, FIFO never full
        set_pattern(0);
        do_start(1'b1, 3'b111);
        chk("model_header", exp_q[0], 32'hD500_006F);
        wait_frames();
        chk("lit_header",  cap[0],   32'hD500_006F);
        chk("lit_ifid_lo", cap[1],   32'h3333_4444);
        chk("lit_ifid_hi", cap[2],   32'h1111_2222);
        chk("lit_idex_top", cap[7],  32'h0000_07FF);
        chk("lit_r0",      cap[14],  32'h0000_0000);
        chk("lit_r1",      cap[15],  32'h0101_0101);
        chk("lit_r31",     cap[45],  32'h1F1F_1F1F);
        chk("lit_mem0",    cap[46],  32'hA000_0000);
        chk("lit_mem63",   cap[109], 32'hA000_003F);
        first_trailer = cap[110];

        // Memory section excluded
        set_pattern(1);
        do_start(1'b0, 3'b111);
        wait_frames();
        chk("lit_hdr_nomem", cap[0],  32'hD500_002F);
        chk("lit_ifid_lo2",  cap[1],  32'h0BAD_F00D);
        chk("lit_idex_top2", cap[7],  32'h0000_02A5);
        chk("lit_exmem_top", cap[10], 32'h0000_0C3C);
        chk("lit_memwb_top", cap[13], 32'h0000_005B);
        chk("lit_r31_nomem", cap[45], 32'h1F1F_1F1F);

        // Random back-pressure
        set_pattern(0);
        bp_on = 1'b1;
        do_start(1'b1, 3'b111);
        wait_frames();
        bp_on = 1'b0;
        i_fifo_full = 1'b0;
        chk("bp_trailer_same", cap[110], first_trailer);

        // Starts while busy and in the DONE cycle are ignored
        do_start(1'b1, 3'b111);
        repeat (10) tick();
        start_v = 3'b111;
        tick();
        start_v = '0;
        c = 0;
        while (c < 2000 && !done_o[0]) begin
            tick();
            c++;
        end
        chk("reach_done_i0", 32'(done_o[0]), 32'd1);
        start_v = 3'b001;
        tick();
        start_v = '0;
        wait_frames();
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("no_restart_i0", 32'(busy_o[0]), 32'd0);
        end
        do_start(1'b1, 3'b111);
        wait_frames();
        chk("second_frame_trailer", cap[110], first_trailer);

        // Reset in the middle of a frame
        do_start(1'b1, 3'b111);
        c = 0;
        while (c < 2000 && ptr[0] < 20) begin
            tick();
            c++;
        end
        chk("reached_20_writes", 32'(ptr[0]), 32'd20);
        i_reset = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (2) tick();
        i_reset = 1'b1;
        tick();
        do_start(1'b1, 3'b111);
        wait_frames();
        chk("after_reset_header", cap[0], 32'hD500_006F);
        chk("after_reset_trailer", cap[110], first_trailer);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/debug_dump_serializer.md
Name: debug_dump_serializer

Overview:
Writer side of the debug transmit FIFO, feeding the FIFO the UART transmitter drains. On a dump request it snapshots the four pipeline latches, then streams a framed sequence of 32-bit words into the FIFO: header, latch words, register file contents, optional data-memory words, and an XOR trailer. It drives the register-file and data-memory debug read ports itself and honours FIFO back-pressure. It sits between debug_unit control and fifo_transmitter and replaces hand-sequenced FIFO writes.

Parameters:
DATA_MEM_ADDR_WIDTH, 8, byte address width of the data-memory debug read port
MEM_WORDS, 64, number of 32-bit memory words dumped; byte addresses 0,4,8,...
NUM_REGS, 32, number of registers dumped, index 0..NUM_REGS-1
READ_LATENCY, 1, cycles from address presented to read data valid, for registers and memory, range 0..3

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous, active-low reset
i_start  in  1  one-cycle dump request; ignored while o_busy=1
i_include_mem  in  1  sampled with i_start; 1 = include the memory section
i_IF_ID_latch  in  64  pipeline latch
i_ID_EX_latch  in  139  pipeline latch
i_EX_MEM_latch  in  76  pipeline latch
i_MEM_WB_latch  in  71  pipeline latch
o_reg_addr_to_read  out  5  register index for the debug read port
i_register_content  in  32  register read data
o_addr_to_read_mem_data  out  DATA_MEM_ADDR_WIDTH  memory byte address
i_mem_data_content  in  32  memory read data
i_fifo_full  in  1  FIFO full flag
o_data_to_fifo  out  32  FIFO write data
o_write_en_fifo  out  1  FIFO write strobe
o_busy  out  1  high from the cycle after an accepted i_start until DONE
o_done  out  1  one-cycle pulse after the trailer is written

Behaviour:
- Reset: state IDLE; all outputs 0, including both addresses, o_data_to_fifo, snapshot and checksum. The reset is asynchronous. Asserting it mid-dump drops o_write_en_fifo immediately; no partial frame resumes.
- i_start accepted in IDLE: capture all four latches and i_include_mem; clear the checksum; go to HEADER.
- Frame, in order:
  - Header: word 0xD5000000 | N, where N = total words including header and trailer = 1+13+NUM_REGS+(inc?MEM_WORDS:0)+1. Defaults: N=111 (0x6F), or 47 (0x2F) without memory.
  - Latch words (13), least significant 32 bits first, upper bits zero-padded:
    - IF_ID: 2 words
    - ID_EX: 5 words, last word carries [138:128]
    - EX_MEM: 3 words
    - MEM_WB: 3 words
  - Registers 0..NUM_REGS-1.
  - Memory words, if enabled: address k*4 for k = 0..MEM_WORDS-1; address wraps mod 2^DATA_MEM_ADDR_WIDTH.
  - Trailer: XOR of every preceding word in the frame.
- States: IDLE, HEADER, LATCH, RD_ADDR, RD_WAIT, PUSH, TRAILER, DONE. The read phase (registers, then memory) uses an index counter plus a section flag.
- RD_ADDR drives the address. RD_WAIT holds the address for READ_LATENCY cycles (skipped when the latency is 0), then captures read data into a hold register. PUSH writes the hold register.
- Write rule: o_write_en_fifo=1 only in a cycle where i_fifo_full=0 and a word is pending. o_data_to_fifo is stable while a word is pending. Each word is written exactly once. The checksum updates on the write cycle.
- i_fifo_full high stalls HEADER, LATCH, PUSH and TRAILER indefinitely with no loss, duplication or reordering.
- Addresses hold their last value outside RD_ADDR and RD_WAIT; they return to 0 in IDLE.
- DONE lasts one cycle: o_done=1, o_busy=0 next cycle, return to IDLE. An i_start in the DONE cycle is ignored.
- With an unstalled FIFO, max throughput is one word per cycle in HEADER, LATCH and TRAILER, and one word per READ_LATENCY+2 cycles in the read phase.

Decomposition:
- Shared package:
  - state enum
  - HEADER_MAGIC=8'hD5
  - latch word counts: 2, 5, 3, 3; LATCH_WORDS=13
  - latch widths: 64, 139, 76, 71
- Natural sub-module: dump_word_mux. It is combinational: it selects the 32-bit latch word for an index 0..12 from the snapshot bus. The FSM, counters, checksum and hold register stay in the top module.

Test Plan:
- Snapshot registers: IF_ID=64'h1111_2222_3333_4444, other latches all-ones; regs r[i]=i*0x01010101; mem word k=0xA0000000+k; include_mem=1; FIFO never full -> exactly 111 writes.
  - Word0=0xD500006F.
  - Words1–2 = 0x33334444, 0x11112222.
  - Word7 = 0x000007FF.
  - Reg words r0..r31 in order; 64 memory words at addresses 0..252.
  - Trailer = XOR of words 0..109.
  - o_done pulses once.
- Exclusion: include_mem=0 -> 47 words; header 0xD500002F; o_addr_to_read_mem_data stays 0.
- Back-pressure: toggle i_fifo_full with a random 50% duty -> identical 111-word sequence; no o_write_en_fifo while full.
- Latency: READ_LATENCY=0 and 3, registers modelled with matching delay -> correct register and memory words.
- Busy start: i_start pulsed while busy -> no second frame; a new i_start after o_done -> second frame identical to the first.
- Mid-dump reset: assert i_reset low after the 20th write -> o_write_en_fifo=0 in the same cycle, all outputs 0. Then i_start after release -> full frame from the header.
